// File: rtl/lamp_scheduler.sv
// Lamp pattern scheduler: steps through per-mode lamp sequences and swaps modes only at sequence boundaries.
// Optional macro LAMP_SCHEDULER_PAUSE_EN adds a pause input that freezes the sequence.
module lamp_scheduler #(
    parameter logic [24:0] TICK_DIV = 25'd25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode_req,
    input  logic       req_valid,
`ifdef LAMP_SCHEDULER_PAUSE_EN
    input  logic       pause,
`endif
    output logic       req_ready,
    output logic       applied,
    output logic [1:0] mode_active,
    output logic [1:0] step_idx,
    output logic [2:0] lamps
);

    localparam logic [1:0] MODE_CALM = 2'b00;
    localparam logic [1:0] MODE_R2L  = 2'b01;
    localparam logic [1:0] MODE_L2R  = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    function automatic logic [1:0] last_idx(input logic [1:0] mode);
        case (mode)
            MODE_CALM: last_idx = 2'd1;
            MODE_R2L:  last_idx = 2'd2;
            MODE_L2R:  last_idx = 2'd2;
            default:   last_idx = 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] pattern(input logic [1:0] mode, input logic [1:0] idx);
        pattern = 3'b000;
        case (mode)
            MODE_CALM: pattern = (idx == 2'd0) ? 3'b101 : 3'b010;
            MODE_R2L: begin
                case (idx)
                    2'd0:    pattern = 3'b001;
                    2'd1:    pattern = 3'b010;
                    default: pattern = 3'b100;
                endcase
            end
            MODE_L2R: begin
                case (idx)
                    2'd0:    pattern = 3'b100;
                    2'd1:    pattern = 3'b010;
                    default: pattern = 3'b001;
                endcase
            end
            MODE_OFF: pattern = 3'b000;
            default:  pattern = 3'b000;
        endcase
    endfunction

    logic [24:0] presc;
    logic        run;
    logic        step_now;
    logic        boundary;
    logic        accept;
    logic        pend_valid;
    logic [1:0]  pend_mode;

`ifdef LAMP_SCHEDULER_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    assign step_now  = run && (presc == TICK_DIV - 25'd1);
    assign boundary  = step_now && (step_idx == last_idx(mode_active));
    assign req_ready = ~pend_valid;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (run) begin
            presc <= step_now ? '0 : presc + 25'd1;
        end
    end

    // A request accepted on a boundary edge sees pend_valid low there, so it waits a full sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_active <= MODE_CALM;
            step_idx    <= 2'd0;
            lamps       <= 3'b101;
            pend_valid  <= 1'b0;
            applied     <= 1'b0;
        end else begin
            applied <= 1'b0;
            if (boundary && pend_valid) begin
                mode_active <= pend_mode;
                step_idx    <= 2'd0;
                lamps       <= pattern(pend_mode, 2'd0);
                pend_valid  <= 1'b0;
                applied     <= 1'b1;
            end else begin
                if (boundary) begin
                    step_idx <= 2'd0;
                    lamps    <= pattern(mode_active, 2'd0);
                end else if (step_now) begin
                    step_idx <= step_idx + 2'd1;
                    lamps    <= pattern(mode_active, step_idx + 2'd1);
                end
                if (accept) begin
                    pend_valid <= 1'b1;
                end
            end
        end
    end

    // Only meaningful while pend_valid is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_mode <= mode_req;
        end
    end

endmodule

// File: tb/tb_lamp_scheduler.sv
// Directed bench for lamp_scheduler with TICK_DIV = 2; pause coverage under LAMP_SCHEDULER_PAUSE_EN.
module tb_lamp_scheduler;

    logic       clk;
    logic       reset;
    logic [1:0] mode_req;
    logic       req_valid;
`ifdef LAMP_SCHEDULER_PAUSE_EN
    logic       pause;
`endif
    logic       req_ready;
    logic       applied;
    logic [1:0] mode_active;
    logic [1:0] step_idx;
    logic [2:0] lamps;

    int n_chk  = 0;
    int n_pass = 0;

    lamp_scheduler #(.TICK_DIV(25'd2)) dut (
        .clk        (clk),
        .reset      (reset),
        .mode_req   (mode_req),
        .req_valid  (req_valid),
`ifdef LAMP_SCHEDULER_PAUSE_EN
        .pause      (pause),
`endif
        .req_ready  (req_ready),
        .applied    (applied),
        .mode_active(mode_active),
        .step_idx   (step_idx),
        .lamps      (lamps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_out(input string tag, input logic [2:0] e_lamps, input logic [1:0] e_idx,
                           input logic [1:0] e_mode, input logic e_ready, input logic e_applied);
        chk({tag, ".lamps"},   {29'd0, lamps},       {29'd0, e_lamps});
        chk({tag, ".step"},    {30'd0, step_idx},    {30'd0, e_idx});
        chk({tag, ".mode"},    {30'd0, mode_active}, {30'd0, e_mode});
        chk({tag, ".ready"},   {31'd0, req_ready},   {31'd0, e_ready});
        chk({tag, ".applied"}, {31'd0, applied},     {31'd0, e_applied});
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        mode_req  = 2'b00;
        req_valid = 1'b0;
`ifdef LAMP_SCHEDULER_PAUSE_EN
        pause     = 1'b0;
`endif
        tick(1);
        chk_out("reset", 3'b101, 2'd0, 2'b00, 1'b1, 1'b0);
        reset = 1'b0;

        // Idle CALM: step every 2 edges
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (((k / 2) % 2) == 1) chk_out($sformatf("calm%0d", k), 3'b010, 2'd1, 2'b00, 1'b1, 1'b0);
            else                    chk_out($sformatf("calm%0d", k), 3'b101, 2'd0, 2'b00, 1'b1, 1'b0);
        end

        // Request R2L during CALM step 0, then try to overwrite with L2R
        mode_req = 2'b01; req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
        chk_out("r2l_acc", 3'b101, 2'd0, 2'b00, 1'b0, 1'b0);
        mode_req = 2'b10; req_valid = 1'b1;
        tick(1);
        chk_out("r2l_pend1", 3'b010, 2'd1, 2'b00, 1'b0, 1'b0);
        tick(1);
        chk_out("r2l_pend2", 3'b010, 2'd1, 2'b00, 1'b0, 1'b0);
        req_valid = 1'b0;
        tick(1);
        chk_out("r2l_apply", 3'b001, 2'd0, 2'b01, 1'b1, 1'b1);
        tick(1);
        chk_out("r2l_hold", 3'b001, 2'd0, 2'b01, 1'b1, 1'b0);
        tick(1);
        chk_out("r2l_s1", 3'b010, 2'd1, 2'b01, 1'b1, 1'b0);
        tick(2);
        chk_out("r2l_s2", 3'b100, 2'd2, 2'b01, 1'b1, 1'b0);
        tick(2);
        chk_out("r2l_wrap", 3'b001, 2'd0, 2'b01, 1'b1, 1'b0);

        // OFF requested from R2L step 1, then CALM from OFF
        tick(2);
        chk_out("r2l_s1b", 3'b010, 2'd1, 2'b01, 1'b1, 1'b0);
        mode_req = 2'b11; req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
        chk_out("off_acc", 3'b010, 2'd1, 2'b01, 1'b0, 1'b0);
        tick(1);
        chk_out("off_wait", 3'b100, 2'd2, 2'b01, 1'b0, 1'b0);
        tick(2);
        chk_out("off_apply", 3'b000, 2'd0, 2'b11, 1'b1, 1'b1);
        mode_req = 2'b00; req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
        chk_out("calm_acc", 3'b000, 2'd0, 2'b11, 1'b0, 1'b0);
        tick(1);
        chk_out("calm_apply", 3'b101, 2'd0, 2'b00, 1'b1, 1'b1);

        // Request accepted on the boundary edge waits one more sequence
        tick(2);
        chk_out("bnd_s1", 3'b010, 2'd1, 2'b00, 1'b1, 1'b0);
        tick(1);
        mode_req = 2'b10; req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
        chk_out("bnd_acc", 3'b101, 2'd0, 2'b00, 1'b0, 1'b0);
        tick(2);
        chk_out("bnd_wait", 3'b010, 2'd1, 2'b00, 1'b0, 1'b0);
        tick(2);
        chk_out("l2r_apply", 3'b100, 2'd0, 2'b10, 1'b1, 1'b1);

        // Same-mode request restarts the sequence with a pulse
        tick(2);
        chk_out("l2r_s1", 3'b010, 2'd1, 2'b10, 1'b1, 1'b0);
        mode_req = 2'b10; req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
        chk_out("same_acc", 3'b010, 2'd1, 2'b10, 1'b0, 1'b0);
        tick(1);
        chk_out("l2r_s2", 3'b001, 2'd2, 2'b10, 1'b0, 1'b0);
        tick(2);
        chk_out("same_apply", 3'b100, 2'd0, 2'b10, 1'b1, 1'b1);

`ifdef LAMP_SCHEDULER_PAUSE_EN
        // Pause mid-R2L
        mode_req = 2'b01; req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
        tick(1);
        chk_out("p_l2r_s1", 3'b010, 2'd1, 2'b10, 1'b0, 1'b0);
        tick(2);
        chk_out("p_l2r_s2", 3'b001, 2'd2, 2'b10, 1'b0, 1'b0);
        tick(2);
        chk_out("p_r2l_apply", 3'b001, 2'd0, 2'b01, 1'b1, 1'b1);
        tick(2);
        chk_out("p_r2l_s1", 3'b010, 2'd1, 2'b01, 1'b1, 1'b0);
        pause = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk_out($sformatf("paused%0d", k), 3'b010, 2'd1, 2'b01, 1'b1, 1'b0);
        end
        pause = 1'b0;
        tick(1);
        chk_out("resume1", 3'b010, 2'd1, 2'b01, 1'b1, 1'b0);
        tick(1);
        chk_out("resume2", 3'b100, 2'd2, 2'b01, 1'b1, 1'b0);
        tick(2);
`endif

        // Asynchronous reset with a request pending
        mode_req = 2'b01; req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
        chk("rst_pend.ready", {31'd0, req_ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk_out("async_rst", 3'b101, 2'd0, 2'b00, 1'b1, 1'b0);
        #2 reset = 1'b0;
        tick(1);
        chk_out("post_rst1", 3'b101, 2'd0, 2'b00, 1'b1, 1'b0);
        tick(1);
        chk_out("post_rst2", 3'b010, 2'd1, 2'b00, 1'b1, 1'b0);
        tick(1);
        chk_out("post_rst3", 3'b010, 2'd1, 2'b00, 1'b1, 1'b0);
        tick(1);
        chk_out("post_rst4", 3'b101, 2'd0, 2'b00, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lamp_scheduler.md
LAMP_SCHEDULER -- requirements
Module: lamp_scheduler

Interface
REQ-001 Parameter: TICK_DIV, default 25'd25000000, clk cycles per pattern step (legal range 2 .. 2^25-1).
REQ-002 Port: clk  input  1  system clock; all state advances on posedge clk.
REQ-003 Port: reset  input  1  reset, asynchronous and active-high.
REQ-004 Port: mode_req  input  2  requested mode: 00 CALM, 01 RIGHT_TO_LEFT (R2L), 10 LEFT_TO_RIGHT (L2R), 11 OFF.
REQ-005 Port: req_valid  input  1  mode_req is valid this cycle.
REQ-006 Port: req_ready  output  1  scheduler can accept a request (no request pending).
REQ-007 Port: applied  output  1  one-cycle pulse; the pending mode became active.
REQ-008 Port: mode_active  output  2  mode currently driving the lamps.
REQ-009 Port: step_idx  output  2  position within the active sequence.
REQ-010 Port: lamps  output  3  lamp pattern, bit 2 = left, bit 0 = right; registered.

Function
REQ-011 Prescaler counts 0..TICK_DIV-1 and wraps; a "step" occurs on the edge where the count equals TICK_DIV-1.
REQ-012 Sequences: CALM 101,010 (length 2); R2L 001,010,100 (length 3); L2R 100,010,001 (length 3); OFF 000 (length 1).
REQ-013 lamps shall always equal sequence[mode_active][step_idx]; there are no other lamp values.
REQ-014 Handshake: a request is accepted when req_valid && req_ready; mode_req is captured into a pending register and req_ready drops on the next cycle.
REQ-015 While a request is pending, req_ready = 0 and req_valid is ignored; a new mode_req cannot overwrite the pending mode.
REQ-016 On a step where step_idx is the last index of the active sequence (boundary step):
  - no request pending: step_idx wraps to 0;
  - request pending: mode_active <= pending, step_idx <= 0, lamps <= first pattern of the new mode, req_ready <= 1.
REQ-017 applied is 1 for exactly the one cycle after a pending request is applied, and 0 at all other times.
REQ-018 On a non-boundary step: step_idx increments by 1 and mode_active is unchanged.
REQ-019 A request accepted on the same edge as a boundary step is not applied at that step; it waits for the next boundary step.
REQ-020 A request for the already-active mode is still accepted, applied and pulsed, and restarts the sequence at step 0.
REQ-021 In OFF every step is a boundary step, so a pending request is applied at the next step.
REQ-022 Between steps, lamps, step_idx and mode_active are held.

Reset
REQ-023 While reset = 1, all of the following are forced immediately, independent of clk: prescaler = 0, mode_active = 00, step_idx = 0, lamps = 101, req_ready = 1, applied = 0, pending cleared.
REQ-024 A reset asserted mid-sequence or with a request pending discards the pending request, and no applied pulse follows.
REQ-025 After reset deasserts, the first step occurs TICK_DIV edges later.

Configuration
REQ-026 With macro LAMP_SCHEDULER_PAUSE_EN defined, a 1-bit input port pause is added:
  - while pause = 1, the prescaler, step_idx, lamps and mode_active are frozen;
  - request acceptance continues normally.
REQ-027 With LAMP_SCHEDULER_PAUSE_EN not defined, there is no pause port and the scheduler always runs.

Verification (TICK_DIV = 2)
REQ-028 Reset, then idle for 8 edges -> lamps alternate 101, 010 every 2 edges, step_idx alternates 0, 1, req_ready = 1.
REQ-029 req_valid = 1 with mode_req = 01 for 1 cycle during CALM step 0 -> req_ready = 0; after the CALM step-1 boundary step, lamps = 001 and mode_active = 01; applied pulses once; lamps then go 010, 100, 001.
REQ-030 While 01 is pending, req_valid = 1 with mode_req = 10 -> ignored; mode_active becomes 01, never 10.
REQ-031 Request 11 from R2L step 1 -> OFF is applied only after step 2 completes; lamps = 000; a following request 00 is applied at the next step, giving lamps = 101.
REQ-032 Pending request present, then reset pulsed asynchronously between clock edges -> outputs return to reset values immediately; no applied pulse follows.
REQ-033 With LAMP_SCHEDULER_PAUSE_EN defined, pause = 1 for 6 edges mid-R2L -> lamps and step_idx unchanged; the sequence resumes from the same step after pause deasserts.
